busca_if: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction memory.
- Holds the program counter and drives `endereco` to the memory. The memory returns `instrucao` combinationally in the same cycle.
- Captures the returned word into an IF/ID pipeline register for the decode stage.
- Handles stall, taken-branch/jump redirect with flush, end-of-memory halt, and misaligned-target detection.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/busca_if_reg_if_id.sv | 55 +++++
 rtl/busca_if.sv | 120 ++++++++++++
 tb/tb_busca_if.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front-end pipeline stages.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cpu_pkg;

    localparam int                 INSTR_W = 32;
    localparam logic [31:0]        PC_INC  = 32'd4;
    localparam logic [INSTR_W-1:0] NOP     = 32'h0000_0000;

    // Fetch-stage control state: normal fetch or halted until reset
    typedef enum logic {
        BUSCA  = 1'b0,
        PARADO = 1'b1
    } estado_t;

    // A byte address is word-aligned when its two low bits are zero
    function automatic logic alinhado(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/busca_if_reg_if_id.sv
// IF/ID pipeline register: captures instruction and pc+4, with flush and hold.
// Latency: one cycle from load to output.
// Backpressure: hold when neither load nor flush; flush clears valid only.
module reg_if_id
    import cpu_pkg::*;
#(
    parameter int W = INSTR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         flush_i,
    input  logic [W-1:0] instr_i,
    input  logic [31:0]  pc4_i,
    output logic [W-1:0] instr_o,
    output logic [31:0]  pc4_o,
    output logic         valid_o
);

    logic [W-1:0] instr_q, instr_d;
    logic [31:0]  pc4_q,   pc4_d;
    logic         valid_q, valid_d;

    // Flush beats load; flushed payload is left in place since decode ignores it
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d = instr_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
        end
    end

    // Register with asynchronous clear to a NOP bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/busca_if.sv
// Instruction fetch: drives pc to the instruction memory and fills IF/ID.
// Latency: instruction at pc appears on IF/ID one cycle later; redirect costs one bubble.
// Backpressure: stall holds pc/IF/ID/counter; redirect overrides stall; halt is sticky to reset.
module busca_if
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 32,
    parameter int          CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [31:0]        endereco,
    input  logic [INSTR_W-1:0] instrucao,
    input  logic               stall,
    input  logic               desvio_en,
    input  logic [31:0]        desvio_alvo,
    output logic [INSTR_W-1:0] if_id_instrucao,
    output logic [31:0]        if_id_pc4,
    output logic               if_id_valido,
    output logic               fim,
    output logic               erro_alinh,
    output logic [CNT_W-1:0]   n_buscas
);

    // 33 bits so a memory of 2^30 words still has a representable limit
    localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;

    estado_t          state_q, state_d;
    logic [31:0]      pc_q,    pc_d;
    logic             fim_q,   fim_d;
    logic             erro_q,  erro_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             load_if_id;
    logic             flush_if_id;
    logic [31:0]      pc_mais4;

    assign pc_mais4 = pc_q + PC_INC;

    // Next-state and IF/ID control, in priority: bad redirect, redirect, stall, end of memory, fetch
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fim_d       = fim_q;
        erro_d      = erro_q;
        cnt_d       = cnt_q;
        load_if_id  = 1'b0;
        flush_if_id = 1'b0;
        case (state_q)
            BUSCA: begin
                if (desvio_en && !alinhado(desvio_alvo[1:0])) begin
                    state_d     = PARADO;
                    erro_d      = 1'b1;
                    fim_d       = 1'b1;
                    flush_if_id = 1'b1;
                end else if (desvio_en) begin
                    pc_d        = desvio_alvo;
                    flush_if_id = 1'b1;
                end else if (stall) begin
                    // everything holds
                end else if ({1'b0, pc_q} >= PC_LIMIT) begin
                    state_d     = PARADO;
                    fim_d       = 1'b1;
                    flush_if_id = 1'b1;
                end else begin
                    load_if_id  = 1'b1;
                    pc_d        = pc_mais4;
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end
            PARADO: begin
                // Halted: stall and redirect are ignored, IF/ID keeps emitting bubbles
                fim_d       = 1'b1;
                flush_if_id = 1'b1;
            end
            default: begin
                state_d     = PARADO;
                fim_d       = 1'b1;
                flush_if_id = 1'b1;
            end
        endcase
    end

    // PC, halt flags and fetch counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUSCA;
            pc_q    <= RESET_PC;
            fim_q   <= 1'b0;
            erro_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fim_q   <= fim_d;
            erro_q  <= erro_d;
            cnt_q   <= cnt_d;
        end
    end

    reg_if_id #(
        .W (INSTR_W)
    ) u_reg_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_if_id),
        .flush_i (flush_if_id),
        .instr_i (instrucao),
        .pc4_i   (pc_mais4),
        .instr_o (if_id_instrucao),
        .pc4_o   (if_id_pc4),
        .valid_o (if_id_valido)
    );

    assign endereco   = pc_q;
    assign fim        = fim_q;
    assign erro_alinh = erro_q;
    assign n_buscas   = cnt_q;

endmodule

// File: tb/tb_busca_if.sv
// Bench for busca_if: memory model, scoreboard of expected IF/ID contents.
// Latency: n/a.
// Backpressure: n/a.
module tb_busca_if;

    localparam int CNT_W = 16;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc4;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [31:0]      endereco;
    logic [31:0]      instrucao;
    logic             stall = 1'b0;
    logic             desvio_en = 1'b0;
    logic [31:0]      desvio_alvo = 32'h0;
    logic [31:0]      if_id_instrucao;
    logic [31:0]      if_id_pc4;
    logic             if_id_valido;
    logic             fim;
    logic             erro_alinh;
    logic [CNT_W-1:0] n_buscas;

    logic [31:0] mem [0:31];
    exp_t        sb [$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;

    busca_if #(
        .RESET_PC  (32'h0000_0000),
        .MEM_WORDS (32),
        .CNT_W     (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .endereco        (endereco),
        .instrucao       (instrucao),
        .stall           (stall),
        .desvio_en       (desvio_en),
        .desvio_alvo     (desvio_alvo),
        .if_id_instrucao (if_id_instrucao),
        .if_id_pc4       (if_id_pc4),
        .if_id_valido    (if_id_valido),
        .fim             (fim),
        .erro_alinh      (erro_alinh),
        .n_buscas        (n_buscas)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory
    always_comb begin
        instrucao = 32'h0;
        if (endereco < 32'd128) instrucao = mem[endereco[6:2]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stall = 1'b0; desvio_en = 1'b0; desvio_alvo = 32'h0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (endereco !== 32'h0) begin errors++; $display("FAIL reset_endereco: got %h want %h", endereco, 32'h0); end
        checks++; if (if_id_instrucao !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want %h", if_id_instrucao, 32'h0); end
        checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h want %h", if_id_pc4, 32'h0); end
        checks++; if (if_id_valido !== 1'b0) begin errors++; $display("FAIL reset_valido: got %b want 0", if_id_valido); end
        checks++; if (fim !== 1'b0 || erro_alinh !== 1'b0) begin errors++; $display("FAIL reset_flags: got fim=%b erro=%b want 0 0", fim, erro_alinh); end
        checks++; if (n_buscas !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", n_buscas); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            checks++; if (endereco !== 32'(4*i)) begin errors++; $display("FAIL run_endereco: got %h want %h", endereco, 32'(4*i)); end
            e.ins = mem[i]; e.pc4 = 32'(4*i + 4); sb.push_back(e);
            tick();
            checks++;
            if (if_id_valido !== 1'b1 || sb.size() == 0) begin
                errors++; $display("FAIL run_valido: got valido=%b sb=%0d want 1", if_id_valido, sb.size());
            end else begin
                e = sb.pop_front();
                if (if_id_instrucao !== e.ins || if_id_pc4 !== e.pc4) begin
                    errors++; $display("FAIL run_capture: got %h/%h want %h/%h", if_id_instrucao, if_id_pc4, e.ins, e.pc4);
                end
            end
        end
        checks++; if (n_buscas !== 16'd5) begin errors++; $display("FAIL run_count: got %0d want 5", n_buscas); end
    endtask

    task automatic test_stall();
        do_reset();
        tick(); tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (endereco !== 32'h8 || if_id_instrucao !== 32'h20090003 || if_id_valido !== 1'b1 || n_buscas !== 16'd2) begin
                errors++; $display("FAIL stall_hold: got pc=%h ins=%h v=%b n=%0d want 8 20090003 1 2", endereco, if_id_instrucao, if_id_valido, n_buscas);
            end
        end
        stall = 1'b0;
        e.ins = 32'h01095020; e.pc4 = 32'hC; sb.push_back(e);
        tick();
        checks++;
        if (if_id_valido !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL stall_release_valido: got %b want 1", if_id_valido);
        end else begin
            e = sb.pop_front();
            if (if_id_instrucao !== e.ins || if_id_pc4 !== e.pc4 || n_buscas !== 16'd3) begin
                errors++; $display("FAIL stall_release: got %h/%h n=%0d want %h/%h n=3", if_id_instrucao, if_id_pc4, n_buscas, e.ins, e.pc4);
            end
        end
    endtask

    task automatic test_redirect();
        for (int s = 0; s < 2; s++) begin
            do_reset();
            tick(); tick();
            desvio_en = 1'b1; desvio_alvo = 32'h10; stall = (s == 1);
            tick();
            checks++;
            if (if_id_valido !== 1'b0 || endereco !== 32'h10 || n_buscas !== 16'd2) begin
                errors++; $display("FAIL redirect_bubble(stall=%0d): got v=%b pc=%h n=%0d want 0 10 2", s, if_id_valido, endereco, n_buscas);
            end
            desvio_en = 1'b0; stall = 1'b0;
            e.ins = 32'hAC0B0004; e.pc4 = 32'h14; sb.push_back(e);
            tick();
            checks++;
            if (if_id_valido !== 1'b1 || sb.size() == 0) begin
                errors++; $display("FAIL redirect_valido(stall=%0d): got %b want 1", s, if_id_valido);
            end else begin
                e = sb.pop_front();
                if (if_id_instrucao !== e.ins || if_id_pc4 !== e.pc4) begin
                    errors++; $display("FAIL redirect_target(stall=%0d): got %h/%h want %h/%h", s, if_id_instrucao, if_id_pc4, e.ins, e.pc4);
                end
            end
        end
    endtask

    task automatic test_end_of_mem();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            e.ins = mem[i]; e.pc4 = 32'(4*i + 4); sb.push_back(e);
            tick();
            if (if_id_valido !== 1'b1 || sb.size() == 0) bad++;
            else begin
                e = sb.pop_front();
                if (if_id_instrucao !== e.ins || if_id_pc4 !== e.pc4) bad++;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL eom_fetches: got %0d bad captures want 0", bad); end
        checks++; if (fim !== 1'b0 || endereco !== 32'h80) begin errors++; $display("FAIL eom_pre: got fim=%b pc=%h want 0 80", fim, endereco); end
        tick();
        checks++;
        if (fim !== 1'b1 || if_id_valido !== 1'b0 || endereco !== 32'h80 || erro_alinh !== 1'b0 || n_buscas !== 16'd32) begin
            errors++; $display("FAIL eom_halt: got fim=%b v=%b pc=%h erro=%b n=%0d want 1 0 80 0 32", fim, if_id_valido, endereco, erro_alinh, n_buscas);
        end
        stall = 1'b1; desvio_en = 1'b1; desvio_alvo = 32'h10;
        tick();
        stall = 1'b0; desvio_alvo = 32'h6;
        tick();
        desvio_en = 1'b0;
        tick();
        checks++;
        if (fim !== 1'b1 || if_id_valido !== 1'b0 || endereco !== 32'h80 || erro_alinh !== 1'b0 || n_buscas !== 16'd32) begin
            errors++; $display("FAIL eom_ignore: got fim=%b v=%b pc=%h erro=%b n=%0d want 1 0 80 0 32", fim, if_id_valido, endereco, erro_alinh, n_buscas);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        tick();
        desvio_en = 1'b1; desvio_alvo = 32'h0000_0006;
        tick();
        checks++;
        if (fim !== 1'b1 || erro_alinh !== 1'b1 || endereco !== 32'h4 || if_id_valido !== 1'b0) begin
            errors++; $display("FAIL misalign_halt: got fim=%b erro=%b pc=%h v=%b want 1 1 4 0", fim, erro_alinh, endereco, if_id_valido);
        end
        desvio_en = 1'b0;
        tick(); tick();
        checks++;
        if (fim !== 1'b1 || erro_alinh !== 1'b1 || endereco !== 32'h4 || n_buscas !== 16'd1) begin
            errors++; $display("FAIL misalign_sticky: got fim=%b erro=%b pc=%h n=%0d want 1 1 4 1", fim, erro_alinh, endereco, n_buscas);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(); tick();
        desvio_en = 1'b1; desvio_alvo = 32'h10;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (endereco !== 32'h0 || if_id_valido !== 1'b0 || if_id_instrucao !== 32'h0 || if_id_pc4 !== 32'h0 || n_buscas !== '0 || fim !== 1'b0 || erro_alinh !== 1'b0) begin
            errors++; $display("FAIL async_reset: got pc=%h v=%b ins=%h pc4=%h n=%0d fim=%b erro=%b want all zero", endereco, if_id_valido, if_id_instrucao, if_id_pc4, n_buscas, fim, erro_alinh);
        end
        desvio_en = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        e.ins = mem[0]; e.pc4 = 32'h4; sb.push_back(e);
        tick();
        checks++;
        if (if_id_valido !== 1'b1 || sb.size() == 0 || fim !== 1'b0 || endereco !== 32'h4) begin
            errors++; $display("FAIL async_restart: got v=%b fim=%b pc=%h want 1 0 4", if_id_valido, fim, endereco);
        end else begin
            e = sb.pop_front();
            if (if_id_instrucao !== e.ins || if_id_pc4 !== e.pc4) begin
                errors++; $display("FAIL async_restart_capture: got %h/%h want %h/%h", if_id_instrucao, if_id_pc4, e.ins, e.pc4);
            end
        end
    endtask

    initial begin
        mem[0] = 32'h20080005;
        mem[1] = 32'h20090003;
        mem[2] = 32'h01095020;
        mem[3] = 32'h012A5822;
        mem[4] = 32'hAC0B0004;
        for (int i = 5; i < 32; i++) mem[i] = 32'hE000_0000 | 32'(i);
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_end_of_mem();
        test_misaligned();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
